mem_req_ctrl: RTL and testbench

Request front-end that sits directly upstream of the 8-entry x 8-bit memory and drives its enable/rd_wr/addr/wr_data bus.
- Accepts read/write commands on a valid/ready port and buffers them in a command FIFO.
- Issues them to the memory one at a time, in order.
- Captures read data into a response FIFO, which is drained on a valid/ready response port.
- Converts bursty producer traffic into a legal, single-command-per-cycle memory bus.

---
 rtl/mem_ctrl_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/mem_req_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory request controller.
package mem_ctrl_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  // One queued memory command as it sits in the command FIFO.
  typedef struct packed {
    logic              rd_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // One captured read response.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rsp_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy reporting.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; pointers and level alone decide which entries are valid.
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request front-end: buffers read/write commands, issues them one per cycle
// to the memory bus in order, and queues read data for the response port.
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter  int CMD_DEPTH = 4,
  parameter  int RSP_DEPTH = 2,
  parameter  int RD_LAT    = 1,
  localparam int CMD_LVL_W = $clog2(CMD_DEPTH) + 1,
  localparam int RSP_LVL_W = $clog2(RSP_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_rd_wr,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic [ADDR_W-1:0]    rsp_addr,
  output logic                 mem_enable,
  output logic                 mem_rd_wr,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wr_data,
  input  logic [DATA_W-1:0]    mem_rd_data,
  output logic                 busy,
  output logic [CMD_LVL_W-1:0] cmd_level
);

  localparam int                CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_LAT - 1);

  // Command FIFO signals
  cmd_t                 cmd_in, cmd_head;
  logic                 cmd_push, cmd_pop;
  logic                 cmd_full, cmd_empty;

  // Response FIFO signals
  rsp_t                 rsp_in, rsp_head;
  logic                 rsp_push, rsp_pop;
  logic                 rsp_full, rsp_empty;
  logic [RSP_LVL_W-1:0] rsp_level;

  // Issue FSM and registered memory bus
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic                 mem_enable_q, mem_enable_d;
  logic                 mem_rd_wr_q, mem_rd_wr_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wr_data_q, mem_wr_data_d;
  logic                 take_next, can_issue, rsp_slot_free;

  // Command port: ready is not pop-aware and is held low while in reset.
  assign req_ready = rst && !cmd_full;
  assign cmd_push  = req_valid && req_ready;
  assign cmd_in    = '{rd_wr: req_rd_wr, addr: req_addr, wdata: req_wdata};

  sync_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (cmd_push),
    .wdata_i (cmd_in),
    .pop_i   (cmd_pop),
    .rdata_o (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty),
    .level_o (cmd_level)
  );

  // Read data is captured on the last wait cycle, tagged with the held address.
  assign rsp_push = (state_q == RD_WAIT) && (rd_cnt_q == CNT_LAST);
  assign rsp_in   = '{addr: mem_addr_q, data: mem_rd_data};
  assign rsp_pop  = rsp_valid && rsp_ready;

  sync_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (rsp_push),
    .wdata_i (rsp_in),
    .pop_i   (rsp_pop),
    .rdata_o (rsp_head),
    .full_o  (rsp_full),
    .empty_o (rsp_empty),
    .level_o (rsp_level)
  );

  assign rsp_valid = !rsp_empty;
  assign rsp_data  = rsp_head.data;
  assign rsp_addr  = rsp_head.addr;

  // A capture landing this cycle already claims a slot, so a read issued in
  // the capture cycle must see room beyond it; this keeps the response FIFO
  // from ever overflowing.
  assign rsp_slot_free = rsp_push ? (rsp_level < RSP_LVL_W'(RSP_DEPTH - 1)) : !rsp_full;
  assign can_issue     = !cmd_empty && (!cmd_head.rd_wr || rsp_slot_free);

  // Next-state and next memory-bus values; bus fields hold when not issuing.
  always_comb begin
    state_d       = state_q;
    rd_cnt_d      = rd_cnt_q;
    mem_enable_d  = 1'b0;
    mem_rd_wr_d   = mem_rd_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    cmd_pop       = 1'b0;
    take_next     = 1'b0;

    case (state_q)
      IDLE: take_next = 1'b1;
      ISSUE: begin
        if (mem_rd_wr_q) begin
          state_d  = RD_WAIT;
          rd_cnt_d = '0;
        end else begin
          take_next = 1'b1;
        end
      end
      RD_WAIT: begin
        if (rsp_push) take_next = 1'b1;
        else          rd_cnt_d  = rd_cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Strict order: a stalled read at the head also holds back everything behind it.
    if (take_next) begin
      if (can_issue) begin
        cmd_pop       = 1'b1;
        state_d       = ISSUE;
        mem_enable_d  = 1'b1;
        mem_rd_wr_d   = cmd_head.rd_wr;
        mem_addr_d    = cmd_head.addr;
        mem_wr_data_d = cmd_head.wdata;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // FSM state, wait counter and registered memory bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rd_cnt_q      <= '0;
      mem_enable_q  <= 1'b0;
      mem_rd_wr_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      rd_cnt_q      <= rd_cnt_d;
      mem_enable_q  <= mem_enable_d;
      mem_rd_wr_q   <= mem_rd_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign mem_enable  = mem_enable_q;
  assign mem_rd_wr   = mem_rd_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;

  assign busy = !cmd_empty || (state_q != IDLE) || !rsp_empty;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: an RD_LAT=1 instance and an RD_LAT=3
// instance, each with its own memory model, checked one at a time.
module tb_mem_req_ctrl;
  import mem_ctrl_pkg::*;

  localparam int RD_LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3, sel3;
  logic req_valid, req_rd_wr, rsp_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              d1_req_ready, d1_rsp_valid, d1_mem_enable, d1_mem_rd_wr, d1_busy;
  logic [ADDR_W-1:0] d1_rsp_addr, d1_mem_addr;
  logic [DATA_W-1:0] d1_rsp_data, d1_mem_wr_data, d1_mem_rd_data;
  logic [2:0]        d1_cmd_level;
  logic              d3_req_ready, d3_rsp_valid, d3_mem_enable, d3_mem_rd_wr, d3_busy;
  logic [ADDR_W-1:0] d3_rsp_addr, d3_mem_addr;
  logic [DATA_W-1:0] d3_rsp_data, d3_mem_wr_data, d3_mem_rd_data;
  logic [2:0]        d3_cmd_level;

  mem_req_ctrl #(.CMD_DEPTH(4), .RSP_DEPTH(2), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .req_valid(req_valid), .req_ready(d1_req_ready),
    .req_rd_wr(req_rd_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(d1_rsp_data),
    .rsp_addr(d1_rsp_addr), .mem_enable(d1_mem_enable), .mem_rd_wr(d1_mem_rd_wr),
    .mem_addr(d1_mem_addr), .mem_wr_data(d1_mem_wr_data), .mem_rd_data(d1_mem_rd_data),
    .busy(d1_busy), .cmd_level(d1_cmd_level)
  );

  mem_req_ctrl #(.CMD_DEPTH(4), .RSP_DEPTH(2), .RD_LAT(RD_LAT3)) u_dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid), .req_ready(d3_req_ready),
    .req_rd_wr(req_rd_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(d3_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(d3_rsp_data),
    .rsp_addr(d3_rsp_addr), .mem_enable(d3_mem_enable), .mem_rd_wr(d3_mem_rd_wr),
    .mem_addr(d3_mem_addr), .mem_wr_data(d3_mem_wr_data), .mem_rd_data(d3_mem_rd_data),
    .busy(d3_busy), .cmd_level(d3_cmd_level)
  );

  // Memory models: writes land on the enable edge, read data trails by RD_LAT cycles.
  logic [DATA_W-1:0] m1_mem [8];
  logic [DATA_W-1:0] m1_pipe;
  logic [DATA_W-1:0] m3_mem [8];
  logic [DATA_W-1:0] m3_pipe [3];
  always @(posedge clk) begin
    if (d1_mem_enable && !d1_mem_rd_wr) m1_mem[d1_mem_addr] <= d1_mem_wr_data;
    m1_pipe <= m1_mem[d1_mem_addr];
  end
  always @(posedge clk) begin
    if (d3_mem_enable && !d3_mem_rd_wr) m3_mem[d3_mem_addr] <= d3_mem_wr_data;
    m3_pipe[0] <= m3_mem[d3_mem_addr];
    m3_pipe[1] <= m3_pipe[0];
    m3_pipe[2] <= m3_pipe[1];
  end
  assign d1_mem_rd_data = m1_pipe;
  assign d3_mem_rd_data = m3_pipe[2];

  // View of whichever instance is under test.
  logic              o_req_ready, o_rsp_valid, o_mem_enable, o_mem_rd_wr, o_busy;
  logic [ADDR_W-1:0] o_rsp_addr, o_mem_addr;
  logic [DATA_W-1:0] o_rsp_data, o_mem_wr_data;
  logic [2:0]        o_cmd_level;
  assign o_req_ready   = sel3 ? d3_req_ready   : d1_req_ready;
  assign o_rsp_valid   = sel3 ? d3_rsp_valid   : d1_rsp_valid;
  assign o_mem_enable  = sel3 ? d3_mem_enable  : d1_mem_enable;
  assign o_mem_rd_wr   = sel3 ? d3_mem_rd_wr   : d1_mem_rd_wr;
  assign o_busy        = sel3 ? d3_busy        : d1_busy;
  assign o_rsp_addr    = sel3 ? d3_rsp_addr    : d1_rsp_addr;
  assign o_mem_addr    = sel3 ? d3_mem_addr    : d1_mem_addr;
  assign o_rsp_data    = sel3 ? d3_rsp_data    : d1_rsp_data;
  assign o_mem_wr_data = sel3 ? d3_mem_wr_data : d1_mem_wr_data;
  assign o_cmd_level   = sel3 ? d3_cmd_level   : d1_cmd_level;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus log of every issued command, with the cycle it appeared in.
  cmd_t log_q [$];
  int   cyc_q [$];
  always @(negedge clk) begin
    if (o_mem_enable) begin
      log_q.push_back('{rd_wr: o_mem_rd_wr, addr: o_mem_addr, wdata: o_mem_wr_data});
      cyc_q.push_back(cyc);
    end
  end

  // Flags two RD_LAT=3 reads closer together than one full read turnaround.
  int last_rd_cyc = -100;
  bit rd_overlap  = 1'b0;
  always @(negedge clk) begin
    if (rst3 && d3_mem_enable && d3_mem_rd_wr) begin
      if (cyc - last_rd_cyc <= RD_LAT3) rd_overlap = 1'b1;
      last_rd_cyc = cyc;
    end
  end

  logic [DATA_W-1:0] ref_mem [8];
  rsp_t exp_q [$];
  int   n_pass = 0, n_fail = 0, n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one command and hold it until accepted; model updates on acceptance.
  task automatic send(input logic rd, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, output int waited);
    waited    = 0;
    req_valid = 1'b1;
    req_rd_wr = rd;
    req_addr  = a;
    req_wdata = d;
    while (!o_req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!o_req_ready) begin
      check("send_ready", {31'b0, o_req_ready}, 32'd1);
    end else begin
      @(posedge clk);
      if (rd) exp_q.push_back('{addr: a, data: ref_mem[a]});
      else    ref_mem[a] = d;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Accept cnt responses and compare each against the scoreboard head.
  task automatic drain(input int cnt, input string tag);
    rsp_t got, e;
    int   n;
    rsp_ready = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      n = 0;
      while (!o_rsp_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!o_rsp_valid) begin
        check({tag, "_valid"}, {31'b0, o_rsp_valid}, 32'd1);
        break;
      end
      got = '{addr: o_rsp_addr, data: o_rsp_data};
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else                   e = '1;
      check(tag, got, e);
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, base, n;
    sel3 = 1'b0; rst1 = 1'b1; rst3 = 1'b0;
    req_valid = 1'b0; req_rd_wr = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #1 rst1 = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready",  o_req_ready,  0);
    check("rst_mem_enable", o_mem_enable, 0);
    check("rst_mem_addr",   o_mem_addr,   0);
    check("rst_rsp_valid",  o_rsp_valid,  0);
    check("rst_busy",       o_busy,       0);
    check("rst_cmd_level",  o_cmd_level,  0);
    rst1 = 1'b1;
    @(negedge clk);
    check("rel_req_ready", o_req_ready, 1);

    // Single write
    base = log_q.size();
    send(1'b0, 3'd3, 8'hA5, w);
    repeat (5) @(negedge clk);
    check("wr1_pulses", log_q.size() - base, 1);
    check("wr1_bus", log_q[base], {1'b0, 3'd3, 8'hA5});
    check("wr1_no_rsp", o_rsp_valid, 0);
    check("wr1_idle", o_busy, 0);

    // Write then read back: response 3 cycles after acceptance
    send(1'b0, 3'd7, 8'h5A, w);
    send(1'b1, 3'd7, 8'h00, w);
    n = 0;
    while (!o_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rd_latency", n, 3);
    drain(1, "rd7_rsp");

    // Burst of 6 writes with valid held high: drains one per cycle
    repeat (2) @(negedge clk);
    base = log_q.size();
    for (int i = 0; i < 6; i++) begin
      send(1'b0, 3'(i), 8'(8'h10 + i), w);
      check("burst_ready_wait", w, 0);
    end
    repeat (4) @(negedge clk);
    check("burst_count", log_q.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      check("burst_bus", log_q[base + i], {1'b0, 3'(i), 8'(8'h10 + i)});
      check("burst_cycle", cyc_q[base + i] - cyc_q[base], i);
    end

    // Response back-pressure: two reads complete, third read and writes stall
    base = log_q.size();
    send(1'b1, 3'd7, 8'h00, w);
    send(1'b1, 3'd1, 8'h00, w);
    send(1'b1, 3'd2, 8'h00, w);
    send(1'b0, 3'd6, 8'h66, w);
    send(1'b0, 3'd4, 8'h44, w);
    send(1'b0, 3'd5, 8'h55, w);
    repeat (6) @(negedge clk);
    check("stall_issued", log_q.size() - base, 2);
    check("stall_enable", o_mem_enable, 0);
    check("stall_req_ready", o_req_ready, 0);
    check("stall_cmd_level", o_cmd_level, 4);
    check("stall_rsp_valid", o_rsp_valid, 1);
    check("stall_busy", o_busy, 1);
    drain(3, "stall_rsp");
    repeat (6) @(negedge clk);
    check("stall_issued_all", log_q.size() - base, 6);
    check("stall_bus_rd3", log_q[base + 2], {1'b1, 3'd2, 8'h00});
    check("stall_bus_wr6", log_q[base + 3], {1'b0, 3'd6, 8'h66});
    check("stall_bus_wr4", log_q[base + 4], {1'b0, 3'd4, 8'h44});
    check("stall_bus_wr5", log_q[base + 5], {1'b0, 3'd5, 8'h55});
    check("stall_sb_empty", exp_q.size(), 0);
    check("stall_idle", o_busy, 0);

    // Asynchronous reset while a read is waiting for data
    send(1'b1, 3'd7, 8'h00, w);
    exp_q.delete();
    @(negedge clk);
    check("arst_issue", o_mem_enable, 1);
    @(negedge clk);
    check("arst_busy_before", o_busy, 1);
    #2 rst1 = 1'b0;
    #1;
    check("arst_mem_enable",  o_mem_enable,  0);
    check("arst_mem_rd_wr",   o_mem_rd_wr,   0);
    check("arst_mem_addr",    o_mem_addr,    0);
    check("arst_mem_wr_data", o_mem_wr_data, 0);
    check("arst_rsp_valid",   o_rsp_valid,   0);
    check("arst_req_ready",   o_req_ready,   0);
    check("arst_busy",        o_busy,        0);
    check("arst_cmd_level",   o_cmd_level,   0);
    @(negedge clk);
    rst1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("arst_no_stale_rsp", o_rsp_valid, 0);
    end
    check("arst_busy_after", o_busy, 0);

    // RD_LAT=3 instance: alternating write/read over every address
    rst1 = 1'b0;
    sel3 = 1'b1;
    rst3 = 1'b1;
    repeat (2) @(negedge clk);
    check("lat3_ready", o_req_ready, 1);
    base = log_q.size();
    fork
      begin
        int ws;
        for (int i = 0; i < 8; i++) begin
          send(1'b0, 3'(i), 8'(i * 37 + 3), ws);
          send(1'b1, 3'(i), 8'h00, ws);
        end
      end
      drain(8, "lat3_rsp");
    join
    repeat (6) @(negedge clk);
    check("lat3_issued", log_q.size() - base, 16);
    for (int i = 0; i < 8; i++) begin
      check("lat3_bus_wr", log_q[base + 2 * i],     {1'b0, 3'(i), 8'(i * 37 + 3)});
      check("lat3_bus_rd", log_q[base + 2 * i + 1], {1'b1, 3'(i), 8'h00});
    end
    check("lat3_one_read_in_flight", rd_overlap, 0);
    check("lat3_sb_empty", exp_q.size(), 0);
    check("lat3_idle", o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
